// File: rtl/sddr_cal_pkg.sv
// ---------------------------------------------------------------------------
// sddr_cal_pkg
// Shared definitions for the DDR3 read-capture delay calibrator:
//   - BURST_BEATS : beats per calibration read burst
//   - cal_state_e : sequencer states
//   - expected_beat(k) : fill bit of the training pattern for beat k
//     (even beats all-ones, odd beats all-zeros; the caller replicates it
//     across the DQ width)
// ---------------------------------------------------------------------------
package sddr_cal_pkg;

  localparam int BURST_BEATS = 8;

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    EVAL,
    INC,
    SETTLE,
    CHECK,
    CENTER,
    DONE,
    FAIL
  } cal_state_e;

  function automatic logic expected_beat(input int k);
    return (k % 2) == 0;
  endfunction

endpackage

// File: rtl/sddr_cal_window_tracker.sv
// ---------------------------------------------------------------------------
// sddr_cal_window_tracker
// Tracks the current run of passing taps and the longest run seen so far.
// A run is contiguous in sweep order; ties keep the earlier window.
// Ports:
//   in_ddr_clock_i  clock
//   in_ctl_reset_i  synchronous active-high reset
//   clear_i         zero all windows (start of a sweep)
//   update_i        apply one tap result (pass_i at tap_i)
//   pass_i, tap_i   result and tap of the read being evaluated
//   best_start_o    first tap of the longest window
//   best_len_o      length of the longest window (0 = none found)
// ---------------------------------------------------------------------------
module sddr_cal_window_tracker #(
  parameter int NUM_TAPS = 32,
  localparam int TAP_W = $clog2(NUM_TAPS),
  localparam int LEN_W = $clog2(NUM_TAPS + 1)
) (
  input  logic             in_ddr_clock_i,
  input  logic             in_ctl_reset_i,
  input  logic             clear_i,
  input  logic             update_i,
  input  logic             pass_i,
  input  logic [TAP_W-1:0] tap_i,
  output logic [TAP_W-1:0] best_start_o,
  output logic [LEN_W-1:0] best_len_o
);

  logic [TAP_W-1:0] cur_start_q, best_start_q, cur_start_d;
  logic [LEN_W-1:0] cur_len_q, best_len_q, cur_len_d;

  // NOTE: every combinational output gets a value before any condition so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cur_len_d   = '0;
    cur_start_d = cur_start_q;
    if (pass_i) begin
      cur_len_d = cur_len_q + LEN_W'(1);
      if (cur_len_q == '0) cur_start_d = tap_i;
    end
  end

  // NOTE: the reset is synchronous (sampled on the clock edge, not in the
  // sensitivity list), and state registers use non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge in_ddr_clock_i) begin
    if (in_ctl_reset_i || clear_i) begin
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else if (update_i) begin
      cur_start_q <= cur_start_d;
      cur_len_q   <= cur_len_d;
      // Strictly longer only: an equal-length later run never displaces
      // the earlier one.
      if (cur_len_d > best_len_q) begin
        best_start_q <= cur_start_d;
        best_len_q   <= cur_len_d;
      end
    end
  end

  assign best_start_o = best_start_q;
  assign best_len_o   = best_len_q;

endmodule

// File: rtl/sddr_read_calibrator.sv
// ---------------------------------------------------------------------------
// sddr_read_calibrator
// Read-capture delay training sequencer for the DDR3 PHY. Sweeps the PHY's
// read-clock IDELAY across all taps with one calibration read per tap,
// tracks the longest contiguous passing window and then steps the delay to
// the window centre.
// Optional build macro: SDDR_CAL_DEBUG_EN adds cal_pass_map_o,
// cal_best_start_o and cal_best_len_o.
// Ports:
//   in_ddr_clock_i   DDR/PHY clock
//   in_ctl_reset_i   synchronous active-high reset
//   cal_start_i      start pulse from the init FSM (ignored while busy)
//   cal_busy_o       sweep/centre in progress
//   cal_done_o       sticky: window found and centred
//   cal_fail_o       sticky: no passing tap
//   cal_tap_o        mirror of the PHY tap count
//   rd_req_o         calibration read request, held until rd_ack_i
//   rd_ack_i         controller accepted the read
//   rd_data_valid_i  one-cycle strobe qualifying rd_data_i
//   rd_data_i        captured burst, index 0 = first beat
//   delay_inc_o      one-cycle increment pulse to the PHY read-delay CE
// The IDELAY is not reset here; the PHY must be reset together with this
// block so that tap 0 is a valid assumption.
// ---------------------------------------------------------------------------
module sddr_read_calibrator
  import sddr_cal_pkg::*;
#(
  parameter int DATA_BITS     = 16,
  parameter int NUM_TAPS      = 32,
  parameter int SETTLE_CYCLES = 8,
  parameter int READ_TIMEOUT  = 64,
  localparam int TAP_W = $clog2(NUM_TAPS),
  localparam int LEN_W = $clog2(NUM_TAPS + 1)
) (
  input  logic                                  in_ddr_clock_i,
  input  logic                                  in_ctl_reset_i,
  input  logic                                  cal_start_i,
  output logic                                  cal_busy_o,
  output logic                                  cal_done_o,
  output logic                                  cal_fail_o,
  output logic [TAP_W-1:0]                      cal_tap_o,
  output logic                                  rd_req_o,
  input  logic                                  rd_ack_i,
  input  logic                                  rd_data_valid_i,
  input  logic [BURST_BEATS-1:0][DATA_BITS-1:0] rd_data_i,
  output logic                                  delay_inc_o
`ifdef SDDR_CAL_DEBUG_EN
  ,
  output logic [NUM_TAPS-1:0]                   cal_pass_map_o,
  output logic [TAP_W-1:0]                      cal_best_start_o,
  output logic [LEN_W-1:0]                      cal_best_len_o
`endif
);

  localparam int CNT_MAX = (SETTLE_CYCLES > READ_TIMEOUT) ? SETTLE_CYCLES : READ_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  cal_state_e       state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_next, target_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pass_q;
  logic             centering_q;   // sweep finished, now walking to target
  logic             burst_ok, timeout_hit, settle_done, start_accept;
  logic [TAP_W-1:0] best_start;
  logic [LEN_W-1:0] best_len;

  // Burst compare against the alternating all-ones / all-zeros pattern.
  always_comb begin
    burst_ok = 1'b1;
    for (int k = 0; k < BURST_BEATS; k++) begin
      if (rd_data_i[k] != {DATA_BITS{expected_beat(k)}}) burst_ok = 1'b0;
    end
  end

  assign timeout_hit  = (cnt_q == CNT_W'(READ_TIMEOUT - 1));
  assign settle_done  = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
  assign start_accept = cal_start_i && (state_q inside {IDLE, DONE, FAIL});
  // Hardware tap counter wraps NUM_TAPS-1 -> 0 even for non power-of-two sizes.
  assign tap_next     = (tap_q == TAP_W'(NUM_TAPS - 1)) ? '0 : tap_q + TAP_W'(1);

  always_ff @(posedge in_ddr_clock_i) begin
    if (in_ctl_reset_i) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cal_busy_o  = 1'b1;
    cal_done_o  = 1'b0;
    cal_fail_o  = 1'b0;
    rd_req_o    = 1'b0;
    delay_inc_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        cal_busy_o = 1'b0;
        if (cal_start_i) state_d = REQ;
      end
      REQ: begin
        rd_req_o = 1'b1;
        if (rd_ack_i) state_d = WAIT_DATA;
      end
      WAIT_DATA: if (rd_data_valid_i || timeout_hit) state_d = EVAL;
      EVAL:      state_d = INC;
      INC: begin
        delay_inc_o = 1'b1;
        state_d     = SETTLE;
      end
      SETTLE: begin
        // A wrap to tap 0 during the sweep means every tap has been read;
        // windows therefore never span NUM_TAPS-1 -> 0.
        if (settle_done) begin
          if (centering_q)       state_d = CENTER;
          else if (tap_q == '0)  state_d = CHECK;
          else                   state_d = REQ;
        end
      end
      CHECK:  state_d = (best_len == '0) ? FAIL : CENTER;
      CENTER: state_d = (tap_q == target_q) ? DONE : INC;
      DONE: begin
        cal_busy_o = 1'b0;
        cal_done_o = 1'b1;
        if (cal_start_i) state_d = REQ;
      end
      FAIL: begin
        cal_busy_o = 1'b0;
        cal_fail_o = 1'b1;
        if (cal_start_i) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_ddr_clock_i) begin
    if (in_ctl_reset_i) begin
      tap_q       <= '0;
      target_q    <= '0;
      cnt_q       <= '0;
      pass_q      <= 1'b0;
      centering_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE, FAIL: begin
          if (cal_start_i) begin
            tap_q       <= '0;
            centering_q <= 1'b0;
          end
        end
        REQ: cnt_q <= '0;
        WAIT_DATA: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (rd_data_valid_i)  pass_q <= burst_ok;
          else if (timeout_hit) pass_q <= 1'b0;
        end
        INC: begin
          tap_q <= tap_next;
          cnt_q <= '0;
        end
        SETTLE: cnt_q <= cnt_q + CNT_W'(1);
        CHECK: begin
          target_q    <= best_start + TAP_W'(best_len >> 1);
          centering_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cal_tap_o = tap_q;

  sddr_cal_window_tracker #(
    .NUM_TAPS (NUM_TAPS)
  ) u_window (
    .in_ddr_clock_i (in_ddr_clock_i),
    .in_ctl_reset_i (in_ctl_reset_i),
    .clear_i        (start_accept),
    .update_i       (state_q == EVAL),
    .pass_i         (pass_q),
    .tap_i          (tap_q),
    .best_start_o   (best_start),
    .best_len_o     (best_len)
  );

`ifdef SDDR_CAL_DEBUG_EN
  logic [NUM_TAPS-1:0] pass_map_q;

  always_ff @(posedge in_ddr_clock_i) begin
    if (in_ctl_reset_i || start_accept) pass_map_q <= '0;
    else if (state_q == EVAL)           pass_map_q[tap_q] <= pass_q;
  end

  assign cal_pass_map_o   = pass_map_q;
  assign cal_best_start_o = best_start;
  assign cal_best_len_o   = best_len;
`endif

endmodule

// File: tb/tb_sddr_read_calibrator.sv
// ---------------------------------------------------------------------------
// tb_sddr_read_calibrator
// Drives the calibrator with a controller/PHY model: reads are acked and
// answered after random latencies, the burst is clean at taps marked passing
// and carries one random flipped bit otherwise. The PHY tap is modelled by
// counting delay_inc_o pulses. Expected window, target and pulse counts are
// derived from the pass mask by searching all windows directly.
// ---------------------------------------------------------------------------
module tb_sddr_read_calibrator;

  localparam int NT = 32;

  logic            in_ddr_clock_i = 1'b0;
  logic            in_ctl_reset_i;
  logic            cal_start_i;
  logic            cal_busy_o, cal_done_o, cal_fail_o;
  logic [4:0]      cal_tap_o;
  logic            rd_req_o, rd_ack_i, rd_data_valid_i;
  logic [7:0][15:0] rd_data_i;
  logic            delay_inc_o;

  int total = 0;
  int bad   = 0;

  logic [NT-1:0] pass_mask = '0;
  int            withhold_tap = -1;
  int            phy_tap = 0;
  int            pulses = 0;
  int            viol = 0;
  bit            data_pending = 1'b0;

  always #5 in_ddr_clock_i = ~in_ddr_clock_i;

  sddr_read_calibrator dut (
    .in_ddr_clock_i  (in_ddr_clock_i),
    .in_ctl_reset_i  (in_ctl_reset_i),
    .cal_start_i     (cal_start_i),
    .cal_busy_o      (cal_busy_o),
    .cal_done_o      (cal_done_o),
    .cal_fail_o      (cal_fail_o),
    .cal_tap_o       (cal_tap_o),
    .rd_req_o        (rd_req_o),
    .rd_ack_i        (rd_ack_i),
    .rd_data_valid_i (rd_data_valid_i),
    .rd_data_i       (rd_data_i),
    .delay_inc_o     (delay_inc_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Longest run of set bits; earliest wins on ties. Every start position is
  // tried and the run from there is measured.
  function automatic void ref_window(input logic [NT-1:0] m, output int bs, output int bl);
    bs = 0;
    bl = 0;
    for (int s = 0; s < NT; s++) begin
      int l = 0;
      while (s + l < NT && m[s + l]) l++;
      if (l > bl) begin
        bl = l;
        bs = s;
      end
    end
  endfunction

  function automatic logic [7:0][15:0] make_burst(input bit good);
    logic [7:0][15:0] b;
    int idx;
    for (int k = 0; k < 8; k++) b[k] = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
    if (!good) begin
      idx = $urandom_range(0, 127);
      b[idx / 16][idx % 16] = ~b[idx / 16][idx % 16];
    end
    return b;
  endfunction

  // PHY tap model and increment-safety monitor, sampled just after each edge.
  initial begin
    forever begin
      @(posedge in_ddr_clock_i);
      #1;
      if (in_ctl_reset_i) phy_tap = 0;
      else if (delay_inc_o) begin
        pulses++;
        phy_tap = (phy_tap + 1) % NT;
        if (rd_req_o || data_pending) viol++;
      end
    end
  end

  // Controller model: ack after 0..2 cycles, data after 0..5 more cycles.
  initial begin
    int read_tap;
    rd_ack_i        = 1'b0;
    rd_data_valid_i = 1'b0;
    rd_data_i       = '0;
    forever begin
      @(negedge in_ddr_clock_i);
      if (rd_req_o && !in_ctl_reset_i) begin
        repeat ($urandom_range(0, 2)) @(negedge in_ddr_clock_i);
        check("tap_at_read", 32'(cal_tap_o), 32'(phy_tap));
        read_tap = phy_tap;
        rd_ack_i = 1'b1;
        if (read_tap != withhold_tap) data_pending = 1'b1;
        @(negedge in_ddr_clock_i);
        rd_ack_i = 1'b0;
        if (read_tap != withhold_tap) begin
          repeat ($urandom_range(0, 5)) @(negedge in_ddr_clock_i);
          rd_data_i       = make_burst(pass_mask[read_tap]);
          rd_data_valid_i = 1'b1;
          @(negedge in_ddr_clock_i);
          rd_data_valid_i = 1'b0;
          data_pending    = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    in_ctl_reset_i = 1'b1;
    repeat (2) @(negedge in_ddr_clock_i);
    in_ctl_reset_i = 1'b0;
  endtask

  task automatic run_cal(input string name, input logic [NT-1:0] mask, input int hold,
                         input bit rst_first);
    logic [NT-1:0] eff;
    int bs, bl, target, cyc;
    if (rst_first) do_reset();
    pass_mask    = mask;
    withhold_tap = hold;
    eff = mask;
    if (hold >= 0) eff[hold] = 1'b0;
    ref_window(eff, bs, bl);
    target = (bl == 0) ? 0 : bs + bl / 2;
    pulses = 0;
    viol   = 0;
    cal_start_i = 1'b1;
    @(negedge in_ddr_clock_i);
    cal_start_i = 1'b0;
    check({name, ":busy"}, 32'(cal_busy_o), 1);
    cyc = 0;
    while (!(cal_done_o || cal_fail_o) && cyc < 6000) begin
      @(negedge in_ddr_clock_i);
      cyc++;
      if (cyc == 100) cal_start_i = 1'b1;   // must be ignored while busy
      else            cal_start_i = 1'b0;
    end
    cal_start_i = 1'b0;
    check({name, ":in_budget"}, 32'(cyc < 6000), 1);
    check({name, ":done"},   32'(cal_done_o), 32'(bl != 0));
    check({name, ":fail"},   32'(cal_fail_o), 32'(bl == 0));
    check({name, ":tap"},    32'(cal_tap_o), 32'(target));
    check({name, ":phy_tap"}, 32'(phy_tap), 32'(target));
    check({name, ":pulses"}, 32'(pulses), 32'(NT + target));
    check({name, ":idle"},   32'(cal_busy_o), 0);
    check({name, ":inc_safe"}, 32'(viol), 0);
  endtask

  initial begin
    int cyc;
    in_ctl_reset_i = 1'b1;
    cal_start_i    = 1'b0;
    repeat (3) @(negedge in_ddr_clock_i);
    check("rst:busy", 32'(cal_busy_o), 0);
    check("rst:done", 32'(cal_done_o), 0);
    check("rst:fail", 32'(cal_fail_o), 0);
    check("rst:tap",  32'(cal_tap_o), 0);
    check("rst:req",  32'(rd_req_o), 0);
    check("rst:inc",  32'(delay_inc_o), 0);
    in_ctl_reset_i = 1'b0;
    @(negedge in_ddr_clock_i);

    run_cal("win10_17", 32'h0003_FC00, -1, 1'b0);
    run_cal("tie",      32'h0070_0038, -1, 1'b1);
    run_cal("all_fail", 32'h0000_0000, -1, 1'b1);
    // FAIL leaves the tap at 0, so a re-run straight from FAIL is consistent.
    run_cal("timeout7", 32'h0000_FFFF, 7, 1'b0);

    // Reset in SETTLE right after the increment to tap 20.
    do_reset();
    pass_mask    = '1;
    withhold_tap = -1;
    cal_start_i  = 1'b1;
    @(negedge in_ddr_clock_i);
    cal_start_i = 1'b0;
    cyc = 0;
    while (phy_tap != 20 && cyc < 3000) begin
      @(negedge in_ddr_clock_i);
      cyc++;
    end
    check("midrst:reached", 32'(cyc < 3000), 1);
    in_ctl_reset_i = 1'b1;
    @(negedge in_ddr_clock_i);
    check("midrst:busy", 32'(cal_busy_o), 0);
    check("midrst:done", 32'(cal_done_o), 0);
    check("midrst:fail", 32'(cal_fail_o), 0);
    check("midrst:tap",  32'(cal_tap_o), 0);
    check("midrst:req",  32'(rd_req_o), 0);
    check("midrst:inc",  32'(delay_inc_o), 0);
    in_ctl_reset_i = 1'b0;
    @(negedge in_ddr_clock_i);
    run_cal("wrap_runs", 32'hF000_0007, -1, 1'b0);
    run_cal("all_pass",  32'hFFFF_FFFF, -1, 1'b1);

    for (int i = 0; i < 4; i++) begin
      run_cal($sformatf("rand%0d", i), NT'($urandom), -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
